control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/instr_decode.sv | 65 ++++++
 rtl/control_unit.sv | 166 ++++++++++++++++
 tb/tb_control_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encoding, opcode map, datapath control codes
// and the decoded-control bundle passed from instr_decode to control_unit.
package cpu_pkg;

    localparam int unsigned OPC_W   = 5;
    localparam int unsigned OP1_W   = 5;
    localparam int unsigned OP2_W   = 20;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RET_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Opcode map
    localparam logic [OPC_W-1:0] OP_ALU_LAST = 5'd11;
    localparam logic [OPC_W-1:0] OP_ADDI     = 5'd12;
    localparam logic [OPC_W-1:0] OP_LOAD     = 5'd13;
    localparam logic [OPC_W-1:0] OP_STORE    = 5'd14;
    localparam logic [OPC_W-1:0] OP_MOVI     = 5'd15;
    localparam logic [OPC_W-1:0] OP_BR_BASE  = 5'd15;
    localparam logic [OPC_W-1:0] OP_JMP      = 5'd22;
    localparam logic [OPC_W-1:0] OP_NOP      = 5'd23;
    localparam logic [OPC_W-1:0] OP_HALT     = 5'd24;

    // ALU code used by ADDI
    localparam logic [OPC_W-1:0] ALU_ADD = 5'd1;

    // ramenable codes
    localparam logic [1:0] RAM_IDLE  = 2'b00;
    localparam logic [1:0] RAM_READ  = 2'b01;
    localparam logic [1:0] RAM_WRITE = 2'b10;

    // pcControl codes (1-6 are conditional branches)
    localparam logic [2:0] PC_INC = 3'd0;
    localparam logic [2:0] PC_JMP = 3'd7;

    // writecode codes
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_NUM2 = 2'd1;

    typedef struct packed {
        logic [OPC_W-1:0] alucode;
        logic [OP1_W-1:0] op1;
        logic [OP2_W-1:0] op2;
        logic             imm;
        logic             flag;
        logic [1:0]       ram;
        logic [2:0]       pc_ctrl;
        logic [1:0]       wcode;
        logic             reg_write;
        logic             halt;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: instruction word -> control bundle.
import cpu_pkg::*;

module instr_decode (
    input  logic [INSTR_W-1:0] instr_i,
    output ctrl_t              ctrl_o,
    output logic               illegal_o
);

    logic [OPC_W-1:0] opcode;

    assign opcode = instr_i[31:27];

    // Map opcode to control fields; illegal words fall through as a NOP
    always_comb begin
        ctrl_o         = '0;
        ctrl_o.op1     = instr_i[26:22];
        ctrl_o.op2     = instr_i[19:0];
        illegal_o      = 1'b0;
        if ((instr_i[21:20] != 2'b00) || (opcode > OP_HALT)) begin
            illegal_o = 1'b1;
        end else if (opcode <= OP_ALU_LAST) begin
            ctrl_o.alucode   = opcode;
            ctrl_o.wcode     = WB_ALU;
            ctrl_o.reg_write = 1'b1;
        end else begin
            case (opcode)
                OP_ADDI: begin
                    ctrl_o.alucode   = ALU_ADD;
                    ctrl_o.imm       = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                OP_LOAD: begin
                    ctrl_o.ram       = RAM_READ;
                    ctrl_o.imm       = 1'b1;
                    ctrl_o.flag      = 1'b1;
                    ctrl_o.wcode     = WB_NUM2;
                    ctrl_o.reg_write = 1'b1;
                end
                OP_STORE: begin
                    ctrl_o.ram = RAM_WRITE;
                end
                OP_MOVI: begin
                    ctrl_o.imm       = 1'b1;
                    ctrl_o.wcode     = WB_NUM2;
                    ctrl_o.reg_write = 1'b1;
                end
                OP_JMP: begin
                    ctrl_o.pc_ctrl = PC_JMP;
                end
                OP_NOP: begin
                    ctrl_o.pc_ctrl = PC_INC;
                end
                OP_HALT: begin
                    ctrl_o.halt = 1'b1;
                end
                // Remaining legal opcodes 16-21 are the conditional branches
                default: begin
                    ctrl_o.pc_ctrl = 3'(opcode - OP_BR_BASE);
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch handshake, decode latch, memory wait,
// write-back strobes, retire counter and fetch-timeout halt.
import cpu_pkg::*;

module control_unit #(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned MEM_LAT       = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               fetch_req,
    output logic [OPC_W-1:0]   alucode,
    output logic [OP1_W-1:0]   op1,
    output logic [OP2_W-1:0]   op2,
    output logic               imControl,
    output logic               flag,
    output logic               regenable,
    output logic [1:0]         ramenable,
    output logic [2:0]         pcControl,
    output logic [1:0]         writecode,
    output logic               pc_en,
    output logic               halted,
    output logic               fetch_err,
    output logic               illegal,
    output logic [RET_W-1:0]   retired
);

    localparam int unsigned FCNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam int unsigned MCNT_W = 4;

    state_e             state_q,     state_d;
    logic [FCNT_W-1:0]  fcnt_q,      fcnt_d;
    logic [MCNT_W-1:0]  mcnt_q,      mcnt_d;
    ctrl_t              ctrl_q,      ctrl_d;
    logic               fetch_req_q, fetch_req_d;
    logic               regen_q,     regen_d;
    logic [1:0]         ramen_q,     ramen_d;
    logic               pc_en_q,     pc_en_d;
    logic               halted_q,    halted_d;
    logic               ferr_q,      ferr_d;
    logic               illegal_q,   illegal_d;
    logic [RET_W-1:0]   retired_q,   retired_d;

    ctrl_t              dec_ctrl;
    logic               dec_illegal;

    instr_decode u_decode (
        .instr_i   (instr),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // Next state, counters and registered-output values
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        mcnt_d      = mcnt_q;
        ctrl_d      = ctrl_q;
        illegal_d   = 1'b0;
        ferr_d      = ferr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                fcnt_d  = '0;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    state_d   = ST_DECODE;
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                end else if (fcnt_q == FCNT_W'(FETCH_TIMEOUT - 1)) begin
                    state_d = ST_HALT;
                    ferr_d  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
            ST_DECODE: begin
                state_d = ctrl_q.halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (ctrl_q.ram != RAM_IDLE) begin
                    state_d = ST_MEM;
                    mcnt_d  = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mcnt_q == MCNT_W'(MEM_LAT - 1)) begin
                    state_d = ST_WB;
                end else begin
                    mcnt_d = mcnt_q + MCNT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                fcnt_d  = '0;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes follow the state being entered so they line up with it
        fetch_req_d = (state_d == ST_FETCH);
        regen_d     = (state_d == ST_WB) && ctrl_d.reg_write;
        ramen_d     = (state_d == ST_MEM) ? ctrl_d.ram : RAM_IDLE;
        pc_en_d     = (state_d == ST_WB);
        halted_d    = (state_d == ST_HALT);
        retired_d   = (state_d == ST_WB) ? retired_q + RET_W'(1) : retired_q;
    end

    // State, counter and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            mcnt_q      <= '0;
            ctrl_q      <= '0;
            fetch_req_q <= 1'b0;
            regen_q     <= 1'b0;
            ramen_q     <= RAM_IDLE;
            pc_en_q     <= 1'b0;
            halted_q    <= 1'b0;
            ferr_q      <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            mcnt_q      <= mcnt_d;
            ctrl_q      <= ctrl_d;
            fetch_req_q <= fetch_req_d;
            regen_q     <= regen_d;
            ramen_q     <= ramen_d;
            pc_en_q     <= pc_en_d;
            halted_q    <= halted_d;
            ferr_q      <= ferr_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    assign fetch_req = fetch_req_q;
    assign alucode   = ctrl_q.alucode;
    assign op1       = ctrl_q.op1;
    assign op2       = ctrl_q.op2;
    assign imControl = ctrl_q.imm;
    assign flag      = ctrl_q.flag;
    assign pcControl = ctrl_q.pc_ctrl;
    assign writecode = ctrl_q.wcode;
    assign regenable = regen_q;
    assign ramenable = ramen_q;
    assign pc_en     = pc_en_q;
    assign halted    = halted_q;
    assign fetch_err = ferr_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit against a per-instruction reference model.
module tb_control_unit;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned MLAT    = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_req;
    logic [4:0]  alucode;
    logic [4:0]  op1;
    logic [19:0] op2;
    logic        imControl;
    logic        flag;
    logic        regenable;
    logic [1:0]  ramenable;
    logic [2:0]  pcControl;
    logic [1:0]  writecode;
    logic        pc_en;
    logic        halted;
    logic        fetch_err;
    logic        illegal;
    logic [15:0] retired;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ret_m  = 16'd0;
    logic        fe_m   = 1'b0;

    always #5 clock = ~clock;

    control_unit #(.FETCH_TIMEOUT(TIMEOUT), .MEM_LAT(MLAT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_req   (fetch_req),
        .alucode     (alucode),
        .op1         (op1),
        .op2         (op2),
        .imControl   (imControl),
        .flag        (flag),
        .regenable   (regenable),
        .ramenable   (ramenable),
        .pcControl   (pcControl),
        .writecode   (writecode),
        .pc_en       (pc_en),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .illegal     (illegal),
        .retired     (retired)
    );

    logic [60:0] obs;
    logic [23:0] stat;
    assign obs  = {fetch_req, alucode, op1, op2, imControl, flag, regenable, ramenable,
                   pcControl, writecode, pc_en, halted, fetch_err, illegal, retired};
    assign stat = {fetch_req, regenable, ramenable, pc_en, halted, fetch_err, illegal, retired};

    typedef struct packed {
        logic [4:0]  alu;
        logic [4:0]  o1;
        logic [19:0] o2;
        logic        imm;
        logic        flg;
        logic [1:0]  ram;
        logic [2:0]  pcc;
        logic [1:0]  wc;
        logic        rw;
        logic        bad;
    } ref_t;

    // Expected decode of one instruction word, straight from the opcode table
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        int   op;
        op    = int'(w[31:27]);
        r     = '0;
        r.o1  = w[26:22];
        r.o2  = w[19:0];
        r.bad = (w[21:20] != 2'b00) || (op > 24);
        if (!r.bad) begin
            if (op <= 11) begin
                r.alu = 5'(op); r.rw = 1'b1;
            end else if (op == 12) begin
                r.alu = 5'd1; r.imm = 1'b1; r.rw = 1'b1;
            end else if (op == 13) begin
                r.ram = 2'b01; r.imm = 1'b1; r.flg = 1'b1; r.wc = 2'd1; r.rw = 1'b1;
            end else if (op == 14) begin
                r.ram = 2'b10;
            end else if (op == 15) begin
                r.imm = 1'b1; r.wc = 2'd1; r.rw = 1'b1;
            end else if (op >= 16 && op <= 21) begin
                r.pcc = 3'(op - 15);
            end else if (op == 22) begin
                r.pcc = 3'd7;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ret_m   = 16'd0;
        fe_m    = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n     = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        #3 reset_n  = 1'b0;
        #1;
        checks++;
        if (obs !== 61'd0) begin
            errors++; $display("FAIL reset_async: got %h expected %h", obs, 61'd0);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== 61'd0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", obs, 61'd0);
        end
        reset_n = 1'b1;
        ret_m   = 16'd0;
        fe_m    = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== {1'b1, 60'd0}) begin
            errors++; $display("FAIL reset_first_fetch: got %h expected %h", obs, {1'b1, 60'd0});
        end
    endtask

    task automatic test_timeout();
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            checks++;
            if (obs !== {1'b1, 60'd0}) begin
                errors++; $display("FAIL timeout_wait c=%0d: got %h expected %h", c, obs, {1'b1, 60'd0});
            end
            instr_valid = 1'b0;
            instr       = $urandom;
            @(negedge clock);
        end
        fe_m = 1'b1;
        checks++;
        if (stat !== {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++; $display("FAIL timeout_halt: got %h expected %h", stat,
                               {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
        end
        for (int c = 0; c < 4; c++) begin
            instr_valid = 1'b1;
            instr       = 32'h0860_0001;
            @(negedge clock);
            checks++;
            if (stat !== {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
                errors++; $display("FAIL timeout_sticky c=%0d: got %h expected %h", c, stat,
                                   {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_instructions();
        logic [31:0] words[$];
        int          delays[$];
        words.push_back({5'd1,  5'd3,  2'b00, 20'h20000}); delays.push_back(0);   // ADD
        words.push_back({5'd13, 5'd7,  2'b00, 20'h00044}); delays.push_back(2);   // LOAD
        words.push_back({5'd19, 5'd2,  2'b00, 20'h00010}); delays.push_back(0);   // BNE
        words.push_back({5'd30, 5'd4,  2'b00, 20'h00abc}); delays.push_back(1);   // illegal
        words.push_back({5'd14, 5'd5,  2'b00, 20'h00100}); delays.push_back(0);   // STORE
        words.push_back({5'd15, 5'd6,  2'b00, 20'hfffff}); delays.push_back(15);  // MOVI, last-chance fetch
        words.push_back({5'd12, 5'd8,  2'b00, 20'h00005}); delays.push_back(0);   // ADDI
        words.push_back({5'd22, 5'd0,  2'b00, 20'h00200}); delays.push_back(3);   // JMP
        words.push_back({5'd2,  5'd1,  2'b10, 20'h00001}); delays.push_back(0);   // reserved bits set
        words.push_back({5'd23, 5'd0,  2'b00, 20'h00000}); delays.push_back(0);   // NOP
        for (int n = 0; n < 40; n++) begin
            logic [4:0] op;
            logic [1:0] res;
            op  = 5'($urandom_range(0, 31));
            if (op == 5'd24) op = 5'd23;
            res = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            words.push_back({op, 5'($urandom), res, 20'($urandom)});
            delays.push_back($urandom_range(0, 15));
        end

        foreach (words[i]) begin
            ref_t r;
            int   L;
            r = ref_decode(words[i]);
            L = 3 + ((r.ram != 2'b00) ? int'(MLAT) : 0);
            for (int d = 0; d < delays[i]; d++) begin
                instr_valid = 1'b0;
                instr       = $urandom;
                @(negedge clock);
                checks++;
                if (stat !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, fe_m, 1'b0, ret_m}) begin
                    errors++; $display("FAIL fetch_wait i=%0d: got %h expected %h", i, stat,
                                       {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, fe_m, 1'b0, ret_m});
                end
            end
            instr       = words[i];
            instr_valid = 1'b1;
            for (int k = 1; k <= L; k++) begin
                logic [60:0] exp_v;
                @(negedge clock);
                exp_v = {1'b0, r.alu, r.o1, r.o2, r.imm, r.flg, 1'((k == L) && r.rw),
                         ((k >= 3) && (k < L)) ? r.ram : 2'b00, r.pcc, r.wc, 1'(k == L),
                         1'b0, fe_m, 1'((k == 1) && r.bad),
                         (k == L) ? 16'(ret_m + 16'd1) : ret_m};
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL instr i=%0d w=%h cycle=%0d: got %h expected %h",
                                       i, words[i], k, obs, exp_v);
                end
                instr_valid = 1'($urandom);
                instr       = $urandom;
            end
            ret_m = ret_m + 16'd1;
            @(negedge clock);
            checks++;
            if (stat !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, fe_m, 1'b0, ret_m}) begin
                errors++; $display("FAIL refetch i=%0d: got %h expected %h", i, stat,
                                   {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, fe_m, 1'b0, ret_m});
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_wrap();
        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        ret_m = 16'hFFFE;
        checks++;
        if (retired !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_preset: got %h expected %h", retired, 16'hFFFE);
        end
        for (int n = 0; n < 2; n++) begin
            instr       = {5'd23, 27'd0};
            instr_valid = 1'b1;
            repeat (3) begin
                @(negedge clock);
                instr_valid = 1'b0;
            end
            checks++;
            if (stat !== {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, fe_m, 1'b0, 16'(ret_m + 16'd1)}) begin
                errors++; $display("FAIL wrap_wb n=%0d: got %h expected %h", n, stat,
                                   {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, fe_m, 1'b0, 16'(ret_m + 16'd1)});
            end
            ret_m = ret_m + 16'd1;
            @(negedge clock);
        end
        checks++;
        if (retired !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h expected %h", retired, 16'h0000);
        end
    endtask

    task automatic test_reset_mid_mem();
        instr       = {5'd13, 5'd9, 2'b00, 20'h00077};
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (ramenable !== 2'b01) begin
            errors++; $display("FAIL midmem_ram: got %b expected %b", ramenable, 2'b01);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 61'd0) begin
            errors++; $display("FAIL midmem_async: got %h expected %h", obs, 61'd0);
        end
        @(negedge clock);
        checks++;
        if (obs !== 61'd0) begin
            errors++; $display("FAIL midmem_hold: got %h expected %h", obs, 61'd0);
        end
        reset_n = 1'b1;
        ret_m   = 16'd0;
        fe_m    = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== {1'b1, 60'd0}) begin
            errors++; $display("FAIL midmem_restart: got %h expected %h", obs, {1'b1, 60'd0});
        end
    endtask

    task automatic test_halt();
        logic [60:0] exp_v;
        instr       = {5'd24, 5'd9, 2'b00, 20'h12345};
        instr_valid = 1'b1;
        @(negedge clock);
        exp_v = {1'b0, 5'd0, 5'd9, 20'h12345, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'd0,
                 1'b0, 1'b0, fe_m, 1'b0, ret_m};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL halt_decode: got %h expected %h", obs, exp_v);
        end
        instr_valid = 1'b0;
        @(negedge clock);
        exp_v = {1'b0, 5'd0, 5'd9, 20'h12345, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 2'd0,
                 1'b0, 1'b1, fe_m, 1'b0, ret_m};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL halt_enter: got %h expected %h", obs, exp_v);
        end
        for (int c = 0; c < 6; c++) begin
            instr_valid = 1'($urandom);
            instr       = $urandom;
            @(negedge clock);
            checks++;
            if (stat !== {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, fe_m, 1'b0, ret_m}) begin
                errors++; $display("FAIL halt_stay c=%0d: got %h expected %h", c, stat,
                                   {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, fe_m, 1'b0, ret_m});
            end
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timeout();
        do_reset();
        test_instructions();
        test_wrap();
        test_reset_mid_mem();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
